// File: rtl/aes_block_serializer.sv
// ---------------------------------------------------------------------------
// aes_block_serializer
//
// Captures 128-bit ciphertext blocks straight off the cipher output (which
// cannot be stalled), buffers them in a DEPTH-entry FIFO and replays them as
// a byte stream with a valid/ready handshake, byte 0 of each block first.
//
// Ports
//   clk         single clock, all logic on posedge
//   rst         synchronous active-high reset
//   blk_in      ciphertext block, bit 0 = MSB of byte 0
//   blk_valid   blk_in holds a block this cycle
//   byte_out    current output byte
//   byte_valid  byte_out is valid
//   byte_ready  sink takes byte_out this cycle
//   byte_last   byte_out is byte 15 of its block
//   level       blocks stored in the FIFO (excludes the block being sent)
//   overflow    sticky: a block was dropped since reset
//
// Serializer states
//   state | meaning
//   IDLE  | nothing to send; pops the FIFO head as soon as level > 0
//   SEND  | streaming hold_q, one byte per handshake, index idx_q
// ---------------------------------------------------------------------------
module aes_block_serializer #(
    parameter int DEPTH = 4,
    parameter int LVLW  = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [0:127]    blk_in,
    input  logic            blk_valid,
    output logic [7:0]      byte_out,
    output logic            byte_valid,
    input  logic            byte_ready,
    output logic            byte_last,
    output logic [LVLW-1:0] level,
    output logic            overflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      idx_q, idx_d;
    logic [0:127]    hold_q, hold_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVLW-1:0] level_q, level_d;
    logic            overflow_q, overflow_d;

    logic [0:127]    mem_q [DEPTH];

    logic            hs;
    logic            pop;
    logic            push;
    logic [6:0]      bit_base;

    // ------------------------------------------------------------------
    // Serializer next-state and FIFO pop
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        hold_d   = hold_q;
        rd_ptr_d = rd_ptr_q;
        pop      = 1'b0;
        hs       = (state_q == SEND) && byte_ready;

        case (state_q)
            IDLE: begin
                if (level_q != '0) begin
                    pop = 1'b1;
                end
            end
            SEND: begin
                if (hs) begin
                    if (idx_q != 4'd15) begin
                        idx_d = idx_q + 4'd1;
                    end else if (level_q != '0) begin
                        // Reload on the last handshake so the stream has no bubble.
                        pop = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (pop) begin
            hold_d   = mem_q[rd_ptr_q];
            idx_d    = 4'd0;
            state_d  = SEND;
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // FIFO push, level and overflow
    // ------------------------------------------------------------------
    always_comb begin
        // A full FIFO still takes a block when the head leaves in the same cycle.
        push       = blk_valid && ((level_q < LVLW'(DEPTH)) || pop);
        wr_ptr_d   = push ? (wr_ptr_q + 1'b1) : wr_ptr_q;
        overflow_d = overflow_q | (blk_valid & ~push);

        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= 4'd0;
            hold_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            hold_q     <= hold_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= blk_in;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bit_base   = {idx_q, 3'b000};
    assign byte_valid = (state_q == SEND);
    assign byte_out   = byte_valid ? hold_q[bit_base +: 8] : 8'h00;
    assign byte_last  = byte_valid && (idx_q == 4'd15);
    assign level      = level_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_aes_block_serializer.sv
module tb_aes_block_serializer;

    localparam int DEPTH = 4;
    localparam int LVLW  = $clog2(DEPTH) + 1;

    logic            clk;
    logic            rst;
    logic [0:127]    blk_in;
    logic            blk_valid;
    logic [7:0]      byte_out;
    logic            byte_valid;
    logic            byte_ready;
    logic            byte_last;
    logic [LVLW-1:0] level;
    logic            overflow;

    int errors = 0;
    int checks = 0;

    logic [8:0] exp_q [$];   // {last, byte}

    aes_block_serializer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .blk_in     (blk_in),
        .blk_valid  (blk_valid),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .byte_last  (byte_last),
        .level      (level),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] mk_blk(input logic [7:0] base);
        logic [127:0] b;
        for (int i = 0; i < 16; i++) b[127-8*i -: 8] = base + 8'(i);
        return b;
    endfunction

    // Drive one block for one cycle; queue its bytes if it should be kept.
    task automatic push(input logic [127:0] b, input bit accept);
        blk_in    = b;
        blk_valid = 1'b1;
        if (accept)
            for (int i = 0; i < 16; i++) exp_q.push_back({(i == 15), b[127-8*i -: 8]});
        @(negedge clk);
        blk_valid = 1'b0;
    endtask

    task automatic drain(input bit rnd_ready);
        int n = 0;
        while ((exp_q.size() != 0 || byte_valid) && n < 600) begin
            if (rnd_ready) byte_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        byte_ready = 1'b1;
        chk("drain_done", 32'(n < 600), 32'd1);
        chk("queue_empty", exp_q.size(), 0);
    endtask

    task automatic run_len(output int n);
        int w = 0;
        while (!byte_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        n = 0;
        while (byte_valid && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Monitor: pops the scoreboard on each handshake, checks stall stability.
    logic       prev_stall = 1'b0;
    logic [8:0] prev_out   = '0;
    always @(negedge clk) begin
        #2;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 32'(byte_valid), 32'd1);
                chk("stall_data", {23'd0, byte_last, byte_out}, {23'd0, prev_out});
            end
            if (byte_valid && byte_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got %0h expected none", byte_out);
                end else begin
                    chk("byte", {23'd0, byte_last, byte_out}, {23'd0, exp_q.pop_front()});
                end
            end
            prev_stall = byte_valid && !byte_ready;
            prev_out   = {byte_last, byte_out};
        end
    end

    int n;
    logic [127:0] blk1;

    initial begin
        rst        = 1'b1;
        blk_in     = '0;
        blk_valid  = 1'b0;
        byte_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(byte_valid), 0);
        chk("rst_byte", 32'(byte_out), 0);
        chk("rst_last", 32'(byte_last), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_ovf", 32'(overflow), 0);
        rst = 1'b0;
        byte_ready = 1'b1;
        @(negedge clk);

        // Single block, latency and contiguity
        push(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b1);
        chk("lat_valid_n1", 32'(byte_valid), 0);
        chk("lat_level_n1", 32'(level), 1);
        @(negedge clk);
        chk("lat_valid_n2", 32'(byte_valid), 1);
        chk("lat_first", 32'(byte_out), 32'h69);
        chk("lat_level_n2", 32'(level), 0);
        run_len(n);
        chk("single_run", n, 16);
        drain(1'b0);

        // Back-to-back blocks
        push(mk_blk(8'h00), 1'b1);
        push(mk_blk(8'h10), 1'b1);
        run_len(n);
        chk("b2b_run", n, 32);
        drain(1'b0);

        // Random backpressure
        push(mk_blk(8'h00), 1'b1);
        drain(1'b1);

        // Push and pop together at a full FIFO
        byte_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(mk_blk(8'h30 + 8'(16 * i)), 1'b1);
        chk("full_level", 32'(level), DEPTH);
        byte_ready = 1'b1;
        n = 0;
        while (!byte_last && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("full_last_seen", 32'(byte_last), 1);
        push(mk_blk(8'hc0), 1'b1);
        chk("pushpop_level", 32'(level), DEPTH);
        chk("pushpop_ovf", 32'(overflow), 0);
        drain(1'b0);

        // Overflow: six blocks while stalled, sixth is dropped
        byte_ready = 1'b0;
        blk1 = mk_blk(8'h40);
        push(blk1, 1'b1);
        for (int i = 1; i < 5; i++) push(mk_blk(8'h40 + 8'(16 * i)), 1'b1);
        push(mk_blk(8'hf0), 1'b0);
        chk("ovf_level", 32'(level), DEPTH);
        chk("ovf_set", 32'(overflow), 1);
        repeat (3) @(negedge clk);
        chk("ovf_sticky", 32'(overflow), 1);
        chk("ovf_hold_valid", 32'(byte_valid), 1);
        chk("ovf_hold_byte", 32'(byte_out), 32'h40);
        byte_ready = 1'b1;
        drain(1'b0);
        chk("ovf_sticky_after", 32'(overflow), 1);

        // Reset mid-block with two blocks queued
        push(mk_blk(8'h80), 1'b1);
        push(mk_blk(8'h90), 1'b1);
        push(mk_blk(8'ha0), 1'b1);
        n = 0;
        while (exp_q.size() > 41 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("mid_byte7", 32'(byte_out), 32'h87);
        chk("mid_level", 32'(level), 2);
        rst        = 1'b1;
        byte_ready = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("mid_rst_valid", 32'(byte_valid), 0);
        chk("mid_rst_level", 32'(level), 0);
        chk("mid_rst_ovf", 32'(overflow), 0);
        rst        = 1'b0;
        byte_ready = 1'b1;
        push(mk_blk(8'hb0), 1'b1);
        @(negedge clk);
        chk("post_rst_first", 32'(byte_out), 32'hb0);
        drain(1'b0);

        repeat (3) @(negedge clk);
        chk("idle_end", 32'(byte_valid), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
